// File: rtl/litepcie_usp_pkg.sv
// Shared constants for the UltraScale+ PCIe adapters: RC descriptor field offsets,
// completion fmt/type codes and TLP header dword layout.
package litepcie_usp_pkg;

    // RC descriptor field offsets (first beat, bits [95:0])
    localparam int RC_LADDR_LSB   = 0;
    localparam int RC_LADDR_W     = 7;
    localparam int RC_ERR_LSB     = 12;
    localparam int RC_ERR_W       = 4;
    localparam int RC_BYTECNT_LSB = 16;
    localparam int RC_LOCKED_BIT  = 29;
    localparam int RC_DWCNT_LSB   = 32;
    localparam int RC_DWCNT_W     = 11;
    localparam int RC_STATUS_LSB  = 43;
    localparam int RC_STATUS_W    = 3;
    localparam int RC_EP_BIT      = 46;
    localparam int RC_REQID_LSB   = 48;
    localparam int RC_TAG_LSB     = 64;
    localparam int RC_CPLID_LSB   = 72;
    localparam int RC_TC_LSB      = 89;
    localparam int RC_TC_W        = 3;
    localparam int RC_ATTR_LSB    = 92;

    localparam int RC_TUSER_W        = 75;
    localparam int RC_TUSER_DISC_BIT = 42;

    typedef enum logic [7:0] {
        FMT_TYPE_CPL    = 8'h0A,
        FMT_TYPE_CPLD   = 8'h4A,
        FMT_TYPE_CPLDLK = 8'h4B
    } fmt_type_e;

    localparam int HDR_DW0_LSB = 0;
    localparam int HDR_DW1_LSB = 32;
    localparam int HDR_DW2_LSB = 64;
    localparam int HDR_WIDTH   = 96;

    localparam int OUT_TUSER_W = 4;

endpackage

// File: rtl/axis_skid_buf.sv
// Generic AXIS register slice: output register plus a one-deep skid entry, full throughput.
// in_ready is registered and is low only while the skid entry is occupied.
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             out_load;

    assign accept   = in_valid & in_ready;
    assign out_load = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            if (out_load) begin
                // in_ready is low whenever skid holds data, so no new beat can collide here
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= accept;
                    if (accept) out_data <= in_data;
                end
                in_ready <= 1'b1;
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                in_ready   <= 1'b0;
            end else begin
                in_ready <= ~skid_valid;
            end
        end
    end

endmodule

// File: rtl/m_axis_rc_adapt.sv
// RC adapter: rebuilds a 3-DW completion TLP header from the hard block's RC descriptor.
// Optional error-packet counter enabled by defining M_AXIS_RC_ADAPT_ERR_CNT_EN.
module m_axis_rc_adapt
    import litepcie_usp_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    user_clk,
    input  logic                    user_reset,
    input  logic [DATA_WIDTH-1:0]   m_axis_rc_tdata_a,
    input  logic [DATA_WIDTH/32-1:0] m_axis_rc_tkeep_a,
    input  logic                    m_axis_rc_tlast_a,
    output logic                    m_axis_rc_tready_a,
    input  logic [RC_TUSER_W-1:0]   m_axis_rc_tuser_a,
    input  logic                    m_axis_rc_tvalid_a,
    output logic [DATA_WIDTH-1:0]   m_axis_rc_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_rc_tkeep,
    output logic                    m_axis_rc_tlast,
    input  logic                    m_axis_rc_tready,
    output logic [OUT_TUSER_W-1:0]  m_axis_rc_tuser,
`ifdef M_AXIS_RC_ADAPT_ERR_CNT_EN
    output logic [15:0]             err_count,
`endif
    output logic                    m_axis_rc_tvalid
);

    localparam int BEAT_W = OUT_TUSER_W + 1 + KEEP_WIDTH + DATA_WIDTH;

    logic                   tfirst;
    logic                   err_hold;
    logic                   accept;
    logic                   disc;
    logic                   hdr_err;
    logic                   beat_err;
    logic [HDR_WIDTH-1:0]   hdr;
    logic [7:0]             fmt_type;
    logic [KEEP_WIDTH-1:0]  keep_bytes;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [OUT_TUSER_W-1:0] in_user;
    logic [BEAT_W-1:0]      in_beat;
    logic [BEAT_W-1:0]      out_beat;
    logic                   unused_tuser;

    logic [RC_DWCNT_W-1:0]  dwcnt;
    logic [11:0]            bytecnt;
    logic                   locked;
    logic [RC_STATUS_W-1:0] status;
    logic                   ep;
    logic [RC_ERR_W-1:0]    err;
    logic [15:0]            reqid;
    logic [7:0]             tag;
    logic [15:0]            cplid;
    logic [RC_TC_W-1:0]     tc;
    logic [1:0]             attr;
    logic [RC_LADDR_W-1:0]  laddr;

    assign dwcnt   = m_axis_rc_tdata_a[RC_DWCNT_LSB +: RC_DWCNT_W];
    assign bytecnt = m_axis_rc_tdata_a[RC_BYTECNT_LSB +: 12];
    assign locked  = m_axis_rc_tdata_a[RC_LOCKED_BIT];
    assign status  = m_axis_rc_tdata_a[RC_STATUS_LSB +: RC_STATUS_W];
    assign ep      = m_axis_rc_tdata_a[RC_EP_BIT];
    assign err     = m_axis_rc_tdata_a[RC_ERR_LSB +: RC_ERR_W];
    assign reqid   = m_axis_rc_tdata_a[RC_REQID_LSB +: 16];
    assign tag     = m_axis_rc_tdata_a[RC_TAG_LSB +: 8];
    assign cplid   = m_axis_rc_tdata_a[RC_CPLID_LSB +: 16];
    assign tc      = m_axis_rc_tdata_a[RC_TC_LSB +: RC_TC_W];
    assign attr    = m_axis_rc_tdata_a[RC_ATTR_LSB +: 2];
    assign laddr   = m_axis_rc_tdata_a[RC_LADDR_LSB +: RC_LADDR_W];

    assign disc         = m_axis_rc_tuser_a[RC_TUSER_DISC_BIT];
    assign unused_tuser = ^{m_axis_rc_tuser_a[RC_TUSER_W-1:RC_TUSER_DISC_BIT+1],
                            m_axis_rc_tuser_a[RC_TUSER_DISC_BIT-1:0]};

    always_comb begin
        fmt_type = FMT_TYPE_CPLD;
        if (dwcnt == '0)  fmt_type = FMT_TYPE_CPL;
        else if (locked)  fmt_type = FMT_TYPE_CPLDLK;
    end

    // Lengths of 1024 DW / 4096 bytes wrap to 0 by truncation, matching TLP encoding
    always_comb begin
        hdr = '0;
        hdr[HDR_DW0_LSB +: 32] = {fmt_type, 1'b0, tc, 4'b0, 1'b0, ep, attr, 2'b0, dwcnt[9:0]};
        hdr[HDR_DW1_LSB +: 32] = {cplid, status, 1'b0, bytecnt};
        hdr[HDR_DW2_LSB +: 32] = {reqid, tag, 1'b0, laddr};
    end

    always_comb begin
        keep_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) keep_bytes[i] = m_axis_rc_tkeep_a[i/4];
    end

    assign hdr_err  = ep | (err != '0);
    assign beat_err = tfirst ? hdr_err : err_hold;
    assign in_data  = tfirst ? {m_axis_rc_tdata_a[DATA_WIDTH-1:HDR_WIDTH], hdr} : m_axis_rc_tdata_a;
    assign in_user  = {1'b0, tfirst, disc, beat_err};
    assign in_beat  = {in_user, m_axis_rc_tlast_a, keep_bytes, in_data};
    assign accept   = m_axis_rc_tvalid_a & m_axis_rc_tready_a;

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            tfirst   <= 1'b1;
            err_hold <= 1'b0;
        end else if (accept) begin
            tfirst <= m_axis_rc_tlast_a;
            if (tfirst) err_hold <= hdr_err;
        end
    end

`ifdef M_AXIS_RC_ADAPT_ERR_CNT_EN
    logic pkt_bad;
    logic beat_bad;

    assign beat_bad = beat_err | disc;

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            pkt_bad   <= 1'b0;
            err_count <= '0;
        end else if (accept) begin
            if (m_axis_rc_tlast_a) begin
                pkt_bad <= 1'b0;
                if ((pkt_bad | beat_bad) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end else begin
                pkt_bad <= pkt_bad | beat_bad;
            end
        end
    end
`endif

    axis_skid_buf #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk       (user_clk),
        .rst       (user_reset),
        .in_valid  (m_axis_rc_tvalid_a),
        .in_ready  (m_axis_rc_tready_a),
        .in_data   (in_beat),
        .out_valid (m_axis_rc_tvalid),
        .out_data  (out_beat),
        .out_ready (m_axis_rc_tready)
    );

    assign {m_axis_rc_tuser, m_axis_rc_tlast, m_axis_rc_tkeep, m_axis_rc_tdata} = out_beat;

endmodule
